regfile_mch: RTL and testbench
==============================

Name: regfile_mch

Overview:
- Parametrised multi-channel successor to the single-channel control/status register file.
- Sits between the AXI-Lite-to-MM bridge (wr_*/rd_* strobes) and N_CH frame-transfer engines.
- Adds per-channel frame_size/next_address registers and double-buffered (shadow→active) addresses.
- Adds per-channel start pulses, sticky W1C status with overflow, interrupt aggregation, frame counters and a registered read path.

Parameters:
- N_CH, 4, number of channels (1..8).
- ADDR_W, 8, byte address width; must cover 0x10 + N_CH*0x10.
- VERSION, 32'h0002_0000, constant returned at VERSION register.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- wr_addr  in  ADDR_W  byte write address; bits[1:0] ignored.
- wr_dout  in  32  write data.
- wr_be  in  4  byte enables.
- wr_en  in  1  write strobe, one cycle per write.
- rd_addr  in  ADDR_W  byte read address.
- rd_en  in  1  read strobe.
- rd_din  out  32  read data, registered.
- rd_valid  out  1  rd_din valid, one cycle after rd_en.
- soft_rst  out  1  one-cycle soft-reset pulse.
- ch_start  out  N_CH  per-channel one-cycle start pulse.
- ch_frame_size  out  32*N_CH  per-channel frame size; channel c occupies [32c+31:32c].
- ch_active_addr  out  32*N_CH  per-channel active buffer address.
- ch_frame_done  in  N_CH  per-channel one-cycle frame-complete pulse from engine.
- irq  out  1  registered level interrupt.

Behaviour:
- Address map (byte offsets):
  - Global: 0x00 CTRL, 0x04 STATUS, 0x08 IRQ_EN, 0x0C VERSION (RO).
  - Channel c, base 0x10+c*0x10: +0 FRAME_SIZE (RW), +4 NEXT_ADDR (RW shadow), +8 ACTIVE_ADDR (RO), +C FRAME_CNT (RO).
- Reset: every register, rd_din, rd_valid, soft_rst, ch_start and irq are 0.
- RW registers honour wr_be per byte lane.
- Writes to RO or unmapped addresses, or to channel indices ≥ N_CH, are ignored.
- CTRL:
  - Bit0 = soft_rst; bits[8+c] = start for channel c.
  - Write-1 produces a one-cycle pulse on the output in the cycle after wr_en; the bit then self-clears.
  - Writing 0 has no effect. Reads return 0.
- STATUS:
  - Bit c = done[c], set by ch_frame_done[c].
  - Bit 16+c = ovf[c], set when ch_frame_done[c] arrives while done[c] is already 1.
  - Write-1-to-clear, per byte lane. Set wins over a same-cycle clear.
- IRQ_EN: bits[N_CH-1:0] enable done interrupts; bit 16 enables the OR of all ovf bits. Other bits read 0.
- irq is registered: irq <= |(done & IRQ_EN[N_CH-1:0]) | (IRQ_EN[16] & |ovf). Latency is one cycle after a status change.
- On ch_frame_done[c]:
  - ACTIVE_ADDR[c] <= NEXT_ADDR[c].
  - FRAME_CNT[c] increments, wrapping from 0xFFFFFFFF to 0.
  - If NEXT_ADDR[c] is written in the same cycle, ACTIVE_ADDR gets the old shadow value and the shadow takes the new write.
- Soft reset (the cycle soft_rst is high):
  - Clears STATUS, FRAME_CNT and ACTIVE_ADDR.
  - Preserves FRAME_SIZE, NEXT_ADDR and IRQ_EN.
  - ch_frame_done in that cycle is discarded.
- Read path:
  - rd_din/rd_valid are registered from rd_addr when rd_en=1; latency is exactly 1.
  - Unmapped addresses return 0. Reads have no side effects.
  - A simultaneous read and write to the same register returns the pre-write value.
- Back-to-back rd_en on consecutive cycles is supported, one result per cycle.
- Asserting areset mid-operation clears everything immediately, including in-flight pulses and pending read data.

Decomposition:
- Package regfile_mch_pkg holds:
  - offset constants (OFS_CTRL, OFS_STATUS, OFS_IRQ_EN, OFS_VERSION, CH_BASE, CH_STRIDE, OFS_FSIZE, OFS_NADDR, OFS_AADDR, OFS_FCNT);
  - bit-position constants (CTRL_SRST, CTRL_START_LSB, STS_OVF_LSB, IEN_OVF).
- Sub-module regfile_ch holds one channel's FRAME_SIZE, NEXT_ADDR, ACTIVE_ADDR and FRAME_CNT with their update and read-mux logic; the top level instantiates it N_CH times via generate.

Test Plan:
- Reset then read 0x0C and 0x04 → rd_valid one cycle after rd_en; rd_din = 0x00020000 then 0x00000000; irq = 0.
- Write 0x10=0x000007E0 with be=4'b0011, then be=4'b1100 with data 0xAB000000 → ch_frame_size[31:0] = 0xAB0007E0.
- Write 0x00=0x00000201 → soft_rst and ch_start[1] each high for exactly one cycle after wr_en; a CTRL read returns 0.
- Write 0x24=0x1000_0000, then pulse ch_frame_done[1] → ch_active_addr[63:32] = 0x10000000 and read 0x2C = 1.
  - A second pulse in the same cycle as a write of 0x24=0x2000_0000 → active stays 0x10000000 and shadow becomes 0x20000000.
- IRQ_EN=0x1, then ch_frame_done[0] twice → STATUS = 0x00010001 and irq = 1.
  - Write STATUS=0x00010001 in the same cycle as a third done → STATUS = 0x00000001 (set wins, ovf cleared); then write 0x1 → irq drops one cycle later.
- FRAME_CNT wrap: 2^32 pulses (or a force to 0xFFFFFFFF) then one more done → 0; assert areset mid-read → rd_valid = 0 next cycle.

Source files
------------

// File: rtl/regfile_mch_pkg.sv
// Shared register offsets, bit positions and the byte-lane merge helper
// used by the multi-channel register file.
package regfile_mch_pkg;

    localparam int OFS_CTRL    = 'h00;
    localparam int OFS_STATUS  = 'h04;
    localparam int OFS_IRQ_EN  = 'h08;
    localparam int OFS_VERSION = 'h0C;
    localparam int CH_BASE     = 'h10;
    localparam int CH_STRIDE   = 'h10;
    localparam int OFS_FSIZE   = 'h0;
    localparam int OFS_NADDR   = 'h4;
    localparam int OFS_AADDR   = 'h8;
    localparam int OFS_FCNT    = 'hC;

    localparam int CTRL_SRST      = 0;
    localparam int CTRL_START_LSB = 8;
    localparam int STS_OVF_LSB    = 16;
    localparam int IEN_OVF        = 16;

    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_ch.sv
// One channel's FRAME_SIZE / NEXT_ADDR / ACTIVE_ADDR / FRAME_CNT registers
// with shadow-to-active promotion on frame completion.
module regfile_ch
    import regfile_mch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_soft_rst,
    input  logic        i_wr_fsize,
    input  logic        i_wr_naddr,
    input  logic [31:0] i_wr_data,
    input  logic [3:0]  i_wr_be,
    input  logic        i_frame_done,
    input  logic [1:0]  i_rd_sel,
    output logic [31:0] o_frame_size,
    output logic [31:0] o_active_addr,
    output logic [31:0] o_rd_data
);

    logic [31:0] r_fsize;
    logic [31:0] r_naddr;
    logic [31:0] r_aaddr;
    logic [31:0] r_fcnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fsize <= '0;
            r_naddr <= '0;
            r_aaddr <= '0;
            r_fcnt  <= '0;
        end else begin
            if (i_wr_fsize) r_fsize <= apply_be(r_fsize, i_wr_data, i_wr_be);
            if (i_wr_naddr) r_naddr <= apply_be(r_naddr, i_wr_data, i_wr_be);
            // Active takes the pre-write shadow, so a same-cycle NEXT_ADDR write lands in the next frame.
            if (i_soft_rst) begin
                r_aaddr <= '0;
                r_fcnt  <= '0;
            end else if (i_frame_done) begin
                r_aaddr <= r_naddr;
                r_fcnt  <= r_fcnt + 32'd1;
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        case (i_rd_sel)
            2'(OFS_FSIZE >> 2): o_rd_data = r_fsize;
            2'(OFS_NADDR >> 2): o_rd_data = r_naddr;
            2'(OFS_AADDR >> 2): o_rd_data = r_aaddr;
            2'(OFS_FCNT  >> 2): o_rd_data = r_fcnt;
            default:            o_rd_data = '0;
        endcase
    end

    assign o_frame_size  = r_fsize;
    assign o_active_addr = r_aaddr;

endmodule

// File: rtl/regfile_mch.sv
// Multi-channel control/status register file: global CTRL/STATUS/IRQ_EN/VERSION
// plus N_CH per-channel register blocks, with a one-cycle registered read path.
module regfile_mch
    import regfile_mch_pkg::*;
#(
    parameter int          N_CH    = 4,
    parameter int          ADDR_W  = 8,
    parameter logic [31:0] VERSION = 32'h0002_0000
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [31:0]          wr_dout,
    input  logic [3:0]           wr_be,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic                 rd_en,
    output logic [31:0]          rd_din,
    output logic                 rd_valid,
    output logic                 soft_rst,
    output logic [N_CH-1:0]      ch_start,
    output logic [32*N_CH-1:0]   ch_frame_size,
    output logic [32*N_CH-1:0]   ch_active_addr,
    input  logic [N_CH-1:0]      ch_frame_done,
    output logic                 irq
);

    logic [ADDR_W-1:0] w_wr_a;
    logic [ADDR_W-1:0] w_rd_a;
    logic              w_wr_ctrl;
    logic              w_wr_sts;
    logic              w_wr_ien;
    logic [N_CH-1:0]   w_clr_done;
    logic [N_CH-1:0]   w_clr_ovf;
    logic [31:0]       w_status;
    logic [31:0]       w_ien;
    logic [31:0]       w_rd_data;
    logic [31:0]       w_ch_rd [N_CH];

    logic              r_soft_rst;
    logic [N_CH-1:0]   r_ch_start;
    logic [N_CH-1:0]   r_done;
    logic [N_CH-1:0]   r_ovf;
    logic [N_CH-1:0]   r_ien_done;
    logic              r_ien_ovf;
    logic              r_irq;
    logic [31:0]       r_rd_din;
    logic              r_rd_valid;

    assign w_wr_a    = wr_addr & ~ADDR_W'(3);
    assign w_rd_a    = rd_addr & ~ADDR_W'(3);
    assign w_wr_ctrl = wr_en && (w_wr_a == ADDR_W'(OFS_CTRL));
    assign w_wr_sts  = wr_en && (w_wr_a == ADDR_W'(OFS_STATUS));
    assign w_wr_ien  = wr_en && (w_wr_a == ADDR_W'(OFS_IRQ_EN));

    assign w_clr_done = {N_CH{w_wr_sts & wr_be[0]}} & wr_dout[N_CH-1:0];
    assign w_clr_ovf  = {N_CH{w_wr_sts & wr_be[STS_OVF_LSB/8]}} & wr_dout[STS_OVF_LSB +: N_CH];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_soft_rst <= 1'b0;
            r_ch_start <= '0;
            r_done     <= '0;
            r_ovf      <= '0;
            r_ien_done <= '0;
            r_ien_ovf  <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_soft_rst <= w_wr_ctrl & wr_be[CTRL_SRST/8] & wr_dout[CTRL_SRST];
            r_ch_start <= {N_CH{w_wr_ctrl & wr_be[CTRL_START_LSB/8]}} & wr_dout[CTRL_START_LSB +: N_CH];
            if (w_wr_ien) begin
                if (wr_be[0])         r_ien_done <= wr_dout[N_CH-1:0];
                if (wr_be[IEN_OVF/8]) r_ien_ovf  <= wr_dout[IEN_OVF];
            end
            // A done that coincides with its own clear is an acknowledged frame, not an overflow.
            if (r_soft_rst) begin
                r_done <= '0;
                r_ovf  <= '0;
            end else begin
                r_done <= ch_frame_done | (r_done & ~w_clr_done);
                r_ovf  <= (ch_frame_done & r_done & ~w_clr_done) | (r_ovf & ~w_clr_ovf);
            end
            r_irq <= (|(r_done & r_ien_done)) | (r_ien_ovf & (|r_ovf));
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(CH_BASE + gi*CH_STRIDE);
            logic w_wr_hit;
            logic w_rd_hit;
            logic [31:0] w_rd_ch;

            assign w_wr_hit = wr_en && (w_wr_a[ADDR_W-1:4] == LP_BASE[ADDR_W-1:4]);
            assign w_rd_hit = (w_rd_a[ADDR_W-1:4] == LP_BASE[ADDR_W-1:4]);

            regfile_ch u_ch (
                .i_clk         (aclk),
                .i_rst         (areset),
                .i_soft_rst    (r_soft_rst),
                .i_wr_fsize    (w_wr_hit && (w_wr_a[3:2] == 2'(OFS_FSIZE >> 2))),
                .i_wr_naddr    (w_wr_hit && (w_wr_a[3:2] == 2'(OFS_NADDR >> 2))),
                .i_wr_data     (wr_dout),
                .i_wr_be       (wr_be),
                .i_frame_done  (ch_frame_done[gi]),
                .i_rd_sel      (w_rd_a[3:2]),
                .o_frame_size  (ch_frame_size[32*gi +: 32]),
                .o_active_addr (ch_active_addr[32*gi +: 32]),
                .o_rd_data     (w_rd_ch)
            );

            assign w_ch_rd[gi] = w_rd_hit ? w_rd_ch : 32'd0;
        end
    endgenerate

    always_comb begin
        w_status = '0;
        w_status[N_CH-1:0] = r_done;
        w_status[STS_OVF_LSB +: N_CH] = r_ovf;
        w_ien = '0;
        w_ien[N_CH-1:0] = r_ien_done;
        w_ien[IEN_OVF] = r_ien_ovf;
    end

    always_comb begin
        w_rd_data = '0;
        if (w_rd_a == ADDR_W'(OFS_STATUS))  w_rd_data = w_status;
        if (w_rd_a == ADDR_W'(OFS_IRQ_EN))  w_rd_data = w_ien;
        if (w_rd_a == ADDR_W'(OFS_VERSION)) w_rd_data = VERSION;
        for (int c = 0; c < N_CH; c++) begin
            w_rd_data = w_rd_data | w_ch_rd[c];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rd_din   <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) r_rd_din <= w_rd_data;
        end
    end

    assign rd_din   = r_rd_din;
    assign rd_valid = r_rd_valid;
    assign soft_rst = r_soft_rst;
    assign ch_start = r_ch_start;
    assign irq      = r_irq;

endmodule

// File: tb/tb_regfile_mch.sv
// Directed-vector bench for regfile_mch with hand-computed expected values.
module tb_regfile_mch;

    localparam int N_CH   = 4;
    localparam int ADDR_W = 8;

    logic                 aclk;
    logic                 areset;
    logic [ADDR_W-1:0]    wr_addr;
    logic [31:0]          wr_dout;
    logic [3:0]           wr_be;
    logic                 wr_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 rd_en;
    logic [31:0]          rd_din;
    logic                 rd_valid;
    logic                 soft_rst;
    logic [N_CH-1:0]      ch_start;
    logic [32*N_CH-1:0]   ch_frame_size;
    logic [32*N_CH-1:0]   ch_active_addr;
    logic [N_CH-1:0]      ch_frame_done;
    logic                 irq;

    int n_checks = 0;
    int n_errors = 0;

    regfile_mch #(.N_CH(N_CH), .ADDR_W(ADDR_W), .VERSION(32'h0002_0000)) u_dut (
        .aclk           (aclk),
        .areset         (areset),
        .wr_addr        (wr_addr),
        .wr_dout        (wr_dout),
        .wr_be          (wr_be),
        .wr_en          (wr_en),
        .rd_addr        (rd_addr),
        .rd_en          (rd_en),
        .rd_din         (rd_din),
        .rd_valid       (rd_valid),
        .soft_rst       (soft_rst),
        .ch_start       (ch_start),
        .ch_frame_size  (ch_frame_size),
        .ch_active_addr (ch_active_addr),
        .ch_frame_done  (ch_frame_done),
        .irq            (irq)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge aclk);
        wr_addr = addr; wr_dout = data; wr_be = be; wr_en = 1'b1;
        @(negedge aclk);
        wr_en = 1'b0;
        $display("WR addr=%02h data=%08h be=%04b", addr, data, be);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        @(negedge aclk);
        rd_addr = addr; rd_en = 1'b1;
        @(negedge aclk);
        rd_en = 1'b0;
        $display("RD addr=%02h data=%08h valid=%0b", addr, rd_din, rd_valid);
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk(tag, rd_din, exp);
    endtask

    task automatic pulse_done(input logic [N_CH-1:0] mask);
        @(negedge aclk);
        ch_frame_done = mask;
        @(negedge aclk);
        ch_frame_done = '0;
        $display("DONE mask=%04b", mask);
    endtask

    initial begin
        areset = 1'b1;
        wr_addr = '0; wr_dout = '0; wr_be = '0; wr_en = 1'b0;
        rd_addr = '0; rd_en = 1'b0; ch_frame_done = '0;
        repeat (3) @(negedge aclk);
        areset = 1'b0;

        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_soft_rst", 32'(soft_rst), 32'd0);
        chk("rst_ch_start", 32'(ch_start), 32'd0);
        rd_chk("version", 8'h0C, 32'h0002_0000);
        rd_chk("status_rst", 8'h04, 32'h0000_0000);

        // byte-lane writes to ch0 FRAME_SIZE
        do_write(8'h10, 32'h0000_07E0, 4'b0011);
        do_write(8'h10, 32'hAB00_0000, 4'b1100);
        chk("fsize_be", ch_frame_size[31:0], 32'hAB00_07E0);

        // CTRL pulses: visible the cycle after wr_en, then gone
        @(negedge aclk);
        wr_addr = 8'h00; wr_dout = 32'h0000_0201; wr_be = 4'hF; wr_en = 1'b1;
        @(negedge aclk);
        wr_en = 1'b0;
        $display("WR addr=00 data=00000201 be=1111");
        chk("srst_pulse", 32'(soft_rst), 32'd1);
        chk("start_pulse", 32'(ch_start), 32'h2);
        @(negedge aclk);
        chk("srst_clear", 32'(soft_rst), 32'd0);
        chk("start_clear", 32'(ch_start), 32'h0);
        rd_chk("ctrl_rd", 8'h00, 32'h0);
        rd_chk("fsize_keep", 8'h10, 32'hAB00_07E0);

        // shadow -> active promotion on ch1
        do_write(8'h24, 32'h1000_0000, 4'hF);
        pulse_done(4'b0010);
        chk("active1", ch_active_addr[63:32], 32'h1000_0000);
        rd_chk("fcnt1", 8'h2C, 32'd1);
        @(negedge aclk);
        wr_addr = 8'h24; wr_dout = 32'h2000_0000; wr_be = 4'hF; wr_en = 1'b1;
        ch_frame_done = 4'b0010;
        @(negedge aclk);
        wr_en = 1'b0; ch_frame_done = '0;
        $display("WR addr=24 data=20000000 be=1111 with DONE mask=0010");
        chk("active_same_cyc", ch_active_addr[63:32], 32'h1000_0000);
        rd_chk("shadow_new", 8'h24, 32'h2000_0000);
        rd_chk("aaddr_rd", 8'h28, 32'h1000_0000);
        rd_chk("fcnt2", 8'h2C, 32'd2);
        rd_chk("status_ovf1", 8'h04, 32'h0002_0002);
        do_write(8'h04, 32'hFFFF_FFFF, 4'hF);
        rd_chk("status_w1c", 8'h04, 32'h0);

        // done interrupt and overflow on ch0
        do_write(8'h08, 32'h0000_0001, 4'hF);
        chk("irq_idle", 32'(irq), 32'd0);
        pulse_done(4'b0001);
        pulse_done(4'b0001);
        chk("irq_set", 32'(irq), 32'd1);
        rd_chk("status_ovf0", 8'h04, 32'h0001_0001);
        @(negedge aclk);
        wr_addr = 8'h04; wr_dout = 32'h0001_0001; wr_be = 4'hF; wr_en = 1'b1;
        ch_frame_done = 4'b0001;
        @(negedge aclk);
        wr_en = 1'b0; ch_frame_done = '0;
        $display("WR addr=04 data=00010001 be=1111 with DONE mask=0001");
        rd_chk("status_setwins", 8'h04, 32'h0000_0001);
        @(negedge aclk);
        wr_addr = 8'h04; wr_dout = 32'h0000_0001; wr_be = 4'hF; wr_en = 1'b1;
        @(negedge aclk);
        wr_en = 1'b0;
        $display("WR addr=04 data=00000001 be=1111");
        chk("irq_hold", 32'(irq), 32'd1);
        @(negedge aclk);
        chk("irq_drop", 32'(irq), 32'd0);

        // overflow interrupt only on ch2
        do_write(8'h08, 32'h0001_0000, 4'hF);
        pulse_done(4'b0100);
        @(negedge aclk);
        chk("irq_done_masked", 32'(irq), 32'd0);
        pulse_done(4'b0100);
        @(negedge aclk);
        chk("irq_ovf", 32'(irq), 32'd1);
        rd_chk("ien_rd", 8'h08, 32'h0001_0000);
        do_write(8'h04, 32'hFFFF_FFFF, 4'hF);

        // FRAME_CNT wrap on ch3
        @(negedge aclk);
        force u_dut.g_ch[3].u_ch.r_fcnt = 32'hFFFF_FFFF;
        @(negedge aclk);
        release u_dut.g_ch[3].u_ch.r_fcnt;
        rd_chk("fcnt_max", 8'h4C, 32'hFFFF_FFFF);
        pulse_done(4'b1000);
        rd_chk("fcnt_wrap", 8'h4C, 32'h0);

        // soft reset clears status/active/count, keeps shadow and enables
        do_write(8'h00, 32'h0000_0001, 4'hF);
        rd_chk("srst_fcnt", 8'h2C, 32'h0);
        rd_chk("srst_aaddr", 8'h28, 32'h0);
        rd_chk("srst_naddr", 8'h24, 32'h2000_0000);
        rd_chk("srst_status", 8'h04, 32'h0);
        rd_chk("srst_ien", 8'h08, 32'h0001_0000);

        // back-to-back reads
        @(negedge aclk);
        rd_addr = 8'h0C; rd_en = 1'b1;
        @(negedge aclk);
        chk("b2b_0", rd_din, 32'h0002_0000);
        rd_addr = 8'h10;
        @(negedge aclk);
        chk("b2b_1", rd_din, 32'hAB00_07E0);
        chk("b2b_valid", 32'(rd_valid), 32'd1);
        rd_en = 1'b0;
        $display("RD back-to-back addr=0C,10");

        // read and write of the same register in one cycle
        @(negedge aclk);
        rd_addr = 8'h14; rd_en = 1'b1;
        wr_addr = 8'h14; wr_dout = 32'h0000_0055; wr_be = 4'hF; wr_en = 1'b1;
        @(negedge aclk);
        rd_en = 1'b0; wr_en = 1'b0;
        $display("RDWR addr=14 data=%08h", rd_din);
        chk("rdwr_prewrite", rd_din, 32'h0);
        rd_chk("rdwr_after", 8'h14, 32'h0000_0055);

        // ignored writes: unmapped channel index and RO register
        do_write(8'h50, 32'h0000_1234, 4'hF);
        rd_chk("unmapped", 8'h50, 32'h0);
        do_write(8'h28, 32'h0000_DEAD, 4'hF);
        rd_chk("ro_aaddr", 8'h28, 32'h0);

        // asynchronous reset in the middle of a read
        @(negedge aclk);
        rd_addr = 8'h0C; rd_en = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b1; rd_en = 1'b0;
        @(negedge aclk);
        $display("ARESET during read addr=0C");
        chk("areset_valid", 32'(rd_valid), 32'd0);
        chk("areset_rd_din", rd_din, 32'h0);
        chk("areset_fsize", ch_frame_size[31:0], 32'h0);
        @(negedge aclk);
        areset = 1'b0;
        rd_chk("areset_naddr", 8'h24, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
